// File: rtl/fib_pkg.sv
// Shared widths, argument payload and FSM state encoding for the Fibonacci kernel call driver.
package fib_pkg;

  localparam int unsigned FIB_N_W    = 6;
  localparam int unsigned FIB_DATA_W = 32;

  typedef struct packed {
    logic [FIB_N_W-1:0]    n;
    logic [FIB_DATA_W-1:0] a;
    logic [FIB_DATA_W-1:0] b;
  } fib_args_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } fib_drv_state_e;

endpackage

// File: rtl/fib_lat_counter.sv
// Saturating latency counter with synchronous clear/enable and a terminal-count compare.
module fib_lat_counter
  import fib_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned TERM = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over enable; increments stop at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  // TERM is truncated to W bits, so keep TERM below 2**W.
  assign term_c = (count_q == W'(TERM));

endmodule

// File: rtl/fib_call_driver.sv
// One-call-at-a-time request/response driver for the Fibonacci kernel, reporting kernel latency.
// Optional watchdog enabled by defining FIB_DRIVER_TIMEOUT_EN.
module fib_call_driver
  import fib_pkg::*;
#(
  parameter int unsigned LAT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FIB_N_W-1:0]    req_n,
  input  logic [FIB_DATA_W-1:0] req_a,
  input  logic [FIB_DATA_W-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [FIB_DATA_W-1:0] resp_result,
  output logic [LAT_W-1:0]      resp_lat,
  output logic                  resp_err,
  output logic                  k_r_enable,
  output logic [FIB_N_W-1:0]    k_n,
  output logic [FIB_DATA_W-1:0] k_a,
  output logic [FIB_DATA_W-1:0] k_b,
  input  logic                  k_w_enable,
  input  logic [FIB_DATA_W-1:0] k_result
);

  fib_drv_state_e        state_q,       state_d;
  fib_args_t             args_q,        args_d;
  logic                  req_ready_q,   req_ready_d;
  logic                  resp_valid_q,  resp_valid_d;
  logic [FIB_DATA_W-1:0] resp_result_q, resp_result_d;
  logic [LAT_W-1:0]      resp_lat_q,    resp_lat_d;
  logic                  resp_err_q,    resp_err_d;
  logic                  k_r_enable_q,  k_r_enable_d;

  logic                  cnt_clr_c;
  logic                  cnt_en_c;
  logic                  cnt_term_c;
  logic [LAT_W-1:0]      cnt_val;

  fib_lat_counter #(
    .W    (LAT_W),
    .TERM (TIMEOUT_CYCLES)
  ) u_lat_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .en     (cnt_en_c),
    .count  (cnt_val),
    .term_c (cnt_term_c)
  );

`ifndef FIB_DRIVER_TIMEOUT_EN
  logic unused_cnt_term;
  assign unused_cnt_term = cnt_term_c;
`endif

  // Next-state and registered-output logic; k_w_enable is only trusted in WAIT.
  always_comb begin
    state_d       = state_q;
    args_d        = args_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_lat_d    = resp_lat_q;
    resp_err_d    = resp_err_q;
    k_r_enable_d  = 1'b0;
    cnt_clr_c     = 1'b0;
    cnt_en_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          args_d       = '{n: req_n, a: req_a, b: req_b};
          k_r_enable_d = 1'b1;
          state_d      = LAUNCH;
        end
      end

      LAUNCH: begin
        cnt_clr_c = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        if (k_w_enable) begin
          resp_result_d = k_result;
          resp_lat_d    = cnt_val;
          resp_err_d    = 1'b0;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end
`ifdef FIB_DRIVER_TIMEOUT_EN
        else if (cnt_term_c) begin
          resp_result_d = '0;
          resp_lat_d    = LAT_W'(TIMEOUT_CYCLES);
          resp_err_d    = 1'b1;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end
`endif
        else begin
          cnt_en_c = 1'b1;
        end
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      args_q        <= '0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_lat_q    <= '0;
      resp_err_q    <= 1'b0;
      k_r_enable_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      args_q        <= args_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_lat_q    <= resp_lat_d;
      resp_err_q    <= resp_err_d;
      k_r_enable_q  <= k_r_enable_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_lat    = resp_lat_q;
  assign resp_err    = resp_err_q;
  assign k_r_enable  = k_r_enable_q;
  assign k_n         = args_q.n;
  assign k_a         = args_q.a;
  assign k_b         = args_q.b;

endmodule

// File: tb/tb_fib_call_driver.sv
// Directed bench for fib_call_driver with a behavioural kernel model and a response scoreboard.
module tb_fib_call_driver;

  localparam int unsigned LAT_W  = 16;
  localparam int unsigned TO_CYC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_n = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic [LAT_W-1:0] resp_lat;
  logic        resp_err;
  logic        k_r_enable;
  logic [5:0]  k_n;
  logic [31:0] k_a;
  logic [31:0] k_b;
  logic        k_w_enable;
  logic [31:0] k_result;

  always #5 clk = ~clk;

  fib_call_driver #(
    .LAT_W          (LAT_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_n       (req_n),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_lat    (resp_lat),
    .resp_err    (resp_err),
    .k_r_enable  (k_r_enable),
    .k_n         (k_n),
    .k_a         (k_a),
    .k_b         (k_b),
    .k_w_enable  (k_w_enable),
    .k_result    (k_result)
  );

  typedef struct {
    logic [31:0]      result;
    logic [LAT_W-1:0] lat;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fib_ref(input logic [5:0] n, input logic [31:0] a0,
                                          input logic [31:0] b0);
    logic [31:0] a, b, t;
    a = a0;
    b = b0;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      b = a;
      a = t;
    end
    return a;
  endfunction

  // Kernel model: w_enable rises after 2n+4 WAIT cycles and stays high (stale) until the next load.
  logic        kbusy   = 1'b0;
  logic        kstall  = 1'b0;
  int          kcnt    = 0;
  int          ktarget = 0;
  logic [31:0] kres    = '0;

  always @(posedge clk) begin
    if (k_r_enable) begin
      kbusy   <= 1'b1;
      kcnt    <= 0;
      ktarget <= 2 * int'(k_n) + 4;
      kres    <= fib_ref(k_n, k_a, k_b);
    end else if (kbusy && kcnt < 1000) begin
      kcnt <= kcnt + 1;
    end
  end

  assign k_w_enable = kbusy && !kstall && (kcnt >= ktarget);
  assign k_result   = k_w_enable ? kres : 32'hdead_beef;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},   64'(req_ready),   64'd0);
    check({pfx, "_resp_valid"},  64'(resp_valid),  64'd0);
    check({pfx, "_resp_result"}, 64'(resp_result), 64'd0);
    check({pfx, "_resp_lat"},    64'(resp_lat),    64'd0);
    check({pfx, "_resp_err"},    64'(resp_err),    64'd0);
    check({pfx, "_k_r_enable"},  64'(k_r_enable),  64'd0);
    check({pfx, "_k_args"},      64'({k_n, k_a} | 38'(k_b)), 64'd0);
  endtask

  task automatic drive_req(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b,
                           input bit timed_out);
    exp_t e;
    req_valid = 1'b1;
    req_n     = n;
    req_a     = a;
    req_b     = b;
    if (timed_out) begin
      e.result = '0;
      e.lat    = LAT_W'(TO_CYC);
      e.err    = 1'b1;
    end else begin
      e.result = fib_ref(n, a, b);
      e.lat    = LAT_W'(2 * int'(n) + 4);
      e.err    = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Returns the cycle index of the accepting edge (cyc value seen right after it).
  task automatic wait_accept(output int acc);
    int g = 0;
    while (req_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("req_accept_in_time", 64'(g < 200), 64'd1);
    @(negedge clk);
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  task automatic get_resp(input int acc, input int n, input int stall, input bit chk_timing);
    exp_t        e;
    int          g = 0;
    logic [31:0] r0;
    logic [LAT_W-1:0] l0;
    while (resp_valid !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("resp_in_time", 64'(g < 400), 64'd1);
    // cyc+1 is the next sampling edge, the first one that sees resp_valid high.
    if (chk_timing) check("accept_to_valid", 64'(cyc + 1 - acc), 64'(2 * n + 7));
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("resp_result", 64'(resp_result), 64'(e.result));
      check("resp_lat",    64'(resp_lat),    64'(e.lat));
      check("resp_err",    64'(resp_err),    64'(e.err));
    end
    r0 = resp_result;
    l0 = resp_lat;
    resp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid",      64'(resp_valid),  64'd1);
      check("stall_result",     64'(resp_result), 64'(r0));
      check("stall_lat",        64'(resp_lat),    64'(l0));
      check("stall_req_ready",  64'(req_ready),   64'd0);
      check("stall_no_launch",  64'(k_r_enable),  64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int acc, acc2, hs;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // n=0: result is a, minimum latency.
    drive_req(6'd0, 32'd5, 32'd3, 1'b0);
    wait_accept(acc);
    get_resp(acc, 0, 0, 1'b1);

    // Kernel w_enable is still stale-high from the previous call during this LAUNCH.
    check("stale_w_enable_present", 64'(k_w_enable), 64'd1);
    drive_req(6'd10, 32'd1, 32'd0, 1'b0);
    wait_accept(acc);
    get_resp(acc, 10, 0, 1'b1);

    // Back-to-back with a 5-cycle consumer stall on the first response.
    drive_req(6'd2, 32'd3, 32'd4, 1'b0);
    wait_accept(acc);
    drive_req(6'd1, 32'd1, 32'd0, 1'b0);
    get_resp(acc, 2, 5, 1'b1);
    hs = cyc;
    wait_accept(acc2);
    check("second_launch_after_hs", 64'(acc2 - hs), 64'd1);
    get_resp(acc2, 1, 0, 1'b1);

    // Wrapping arithmetic.
    drive_req(6'd3, 32'hffff_ffff, 32'd2, 1'b0);
    wait_accept(acc);
    get_resp(acc, 3, 0, 1'b1);

    // Reset in the middle of WAIT abandons the call.
    drive_req(6'd20, 32'd9, 32'd1, 1'b0);
    wait_accept(acc);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midwait");
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    drive_req(6'd5, 32'd2, 32'd7, 1'b0);
    wait_accept(acc);
    get_resp(acc, 5, 0, 1'b1);

`ifdef FIB_DRIVER_TIMEOUT_EN
    // Kernel never answers: watchdog closes the call.
    kstall = 1'b1;
    drive_req(6'd4, 32'd1, 32'd1, 1'b1);
    wait_accept(acc);
    get_resp(acc, 4, 0, 1'b0);
    kstall = 1'b0;
    drive_req(6'd0, 32'd42, 32'd0, 1'b0);
    wait_accept(acc);
    get_resp(acc, 0, 0, 1'b1);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
